// File: rtl/seg7_ascii_reader_if.sv
// ---------------------------------------------------------------------------
// seg7_ascii_reader_if
//   Bundles the observed segment bus and the outbound byte stream of the
//   7-segment text reader.
//
//   seg_in       7-segment pattern under observation (active-low, bit0=a..bit6=g)
//   ascii_out    FIFO head byte, meaningful while ascii_valid=1
//   ascii_valid  FIFO not empty
//   ascii_ready  consumer accepts the head byte on an edge with ascii_valid=1
//   decode_err   one-cycle pulse: an unknown pattern was pushed as '?'
//   overflow     one-cycle pulse: a decoded byte was dropped (FIFO full)
//   fifo_count   number of occupied FIFO entries
//
//   master : the reader (drives the stream and status, observes seg_in/ready)
//   slave  : the environment (drives seg_in and ascii_ready)
// ---------------------------------------------------------------------------
interface seg7_ascii_reader_if #(
    parameter int DEPTH = 8
);
    logic [6:0]               seg_in;
    logic [7:0]               ascii_out;
    logic                     ascii_valid;
    logic                     ascii_ready;
    logic                     decode_err;
    logic                     overflow;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport master (
        input  seg_in,
        input  ascii_ready,
        output ascii_out,
        output ascii_valid,
        output decode_err,
        output overflow,
        output fifo_count
    );

    modport slave (
        output seg_in,
        output ascii_ready,
        input  ascii_out,
        input  ascii_valid,
        input  decode_err,
        input  overflow,
        input  fifo_count
    );
endinterface

// File: rtl/seg7_ascii_reader.sv
// ---------------------------------------------------------------------------
// seg7_ascii_reader
//   Watches an active-low 7-segment bus, waits for each new glyph to settle,
//   decodes it to an uppercase ASCII byte and queues it in a small FIFO that
//   drains over a valid/ready stream.
//
//   Parameters
//     STABLE_CYCLES  consecutive identical samples before a glyph is accepted
//     DEPTH          FIFO entries (power of two, >= 2)
//
//   Ports
//     clk    system clock, rising edge
//     reset  asynchronous active-high reset, clears all state and the FIFO
//     bus    seg7_ascii_reader_if.master: seg_in / ascii_ready in,
//            ascii_out / ascii_valid / decode_err / overflow / fifo_count out
// ---------------------------------------------------------------------------
module seg7_ascii_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    seg7_ascii_reader_if.master  bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // -----------------------------------------------------------------------
    // Pattern decode: inverse of the ASCII->segment table. Where a letter and
    // a digit share a pattern the digit is reported. Bit 8 flags an unknown
    // pattern, which is reported as '?'.
    // -----------------------------------------------------------------------
    function automatic logic [8:0] decode_seg(input logic [6:0] pat);
        logic [8:0] res;
        res = {1'b0, 8'h3F};
        case (pat)
            // digits (win every collision with a letter)
            7'h40: res = {1'b0, 8'h30};   // '0' (also O)
            7'h79: res = {1'b0, 8'h31};   // '1'
            7'h24: res = {1'b0, 8'h32};   // '2' (also Z)
            7'h30: res = {1'b0, 8'h33};   // '3'
            7'h19: res = {1'b0, 8'h34};   // '4'
            7'h12: res = {1'b0, 8'h35};   // '5' (also S)
            7'h02: res = {1'b0, 8'h36};   // '6' (also G)
            7'h78: res = {1'b0, 8'h37};   // '7'
            7'h00: res = {1'b0, 8'h38};   // '8'
            7'h10: res = {1'b0, 8'h39};   // '9'
            // letters
            7'h08: res = {1'b0, 8'h41};   // 'A' (also R)
            7'h03: res = {1'b0, 8'h42};   // 'B'
            7'h46: res = {1'b0, 8'h43};   // 'C'
            7'h21: res = {1'b0, 8'h44};   // 'D'
            7'h06: res = {1'b0, 8'h45};   // 'E'
            7'h0E: res = {1'b0, 8'h46};   // 'F'
            7'h09: res = {1'b0, 8'h48};   // 'H' (also K, X)
            7'h4F: res = {1'b0, 8'h49};   // 'I'
            7'h61: res = {1'b0, 8'h4A};   // 'J'
            7'h47: res = {1'b0, 8'h4C};   // 'L'
            7'h6A: res = {1'b0, 8'h4D};   // 'M'
            7'h2B: res = {1'b0, 8'h4E};   // 'N'
            7'h0C: res = {1'b0, 8'h50};   // 'P'
            7'h18: res = {1'b0, 8'h51};   // 'Q'
            7'h07: res = {1'b0, 8'h54};   // 'T'
            7'h41: res = {1'b0, 8'h55};   // 'U'
            7'h63: res = {1'b0, 8'h56};   // 'V'
            7'h55: res = {1'b0, 8'h57};   // 'W'
            7'h11: res = {1'b0, 8'h59};   // 'Y'
            // blank display reads back as a space
            7'h7F: res = {1'b0, 8'h20};
            default: res = {1'b1, 8'h3F};
        endcase
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Capture FSM
    // -----------------------------------------------------------------------
    typedef enum logic {
        ST_WAIT   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         cand_q,  cand_d;
    logic [6:0]         last_q,  last_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               push_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WAIT;
            cand_q  <= SEG_BLANK;
            last_q  <= SEG_BLANK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        push_req = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (bus.seg_in != cand_q) begin
                    cand_d  = bus.seg_in;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (bus.seg_in != cand_q) begin
                    // Any change restarts the stability window.
                    cand_d = bus.seg_in;
                    cnt_d  = CNT_W'(1);
                end else if (cnt_q >= CNT_W'(STABLE_CYCLES)) begin
                    // Settled. Only a glyph different from the previous
                    // settled one is emitted, so a held glyph appears once.
                    push_req = (cand_q != last_q);
                    last_d   = cand_q;
                    state_d  = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output FIFO
    // -----------------------------------------------------------------------
    logic [8:0]     dec;
    logic [7:0]     push_byte;
    logic           push_unknown;

    assign dec          = decode_seg(cand_q);
    assign push_byte    = dec[7:0];
    assign push_unknown = dec[8];

    logic [7:0]     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  rd_next;
    logic [CW-1:0]  count_q,  count_d;
    logic [7:0]     head_q,   head_d;
    logic           err_q,    err_d;
    logic           ovf_q,    ovf_d;

    logic           fifo_empty;
    logic           fifo_full;
    logic           pop;
    logic           push_ok;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign pop        = !fifo_empty && bus.ascii_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign rd_next    = rd_ptr_q + AW'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        err_d    = push_req && push_unknown;
        ovf_d    = push_req && fifo_full && !pop;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_next;
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // head_q mirrors the entry at rd_ptr so ascii_out is a plain register
        // and keeps its last value once the FIFO runs dry.
        if (pop) begin
            if (count_q > CW'(1)) begin
                head_d = mem_q[rd_next];
            end else if (push_ok) begin
                head_d = push_byte;
            end
        end else if (push_ok && fifo_empty) begin
            head_d = push_byte;
        end
    end

    // Storage array carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= 8'h00;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.ascii_out   = head_q;
    assign bus.ascii_valid = !fifo_empty;
    assign bus.decode_err  = err_q;
    assign bus.overflow    = ovf_q;
    assign bus.fifo_count  = count_q;

endmodule

// File: tb/tb_seg7_ascii_reader.sv
// ---------------------------------------------------------------------------
// tb_seg7_ascii_reader
//   Directed bench for seg7_ascii_reader (STABLE_CYCLES=4, DEPTH=8).
//   Inputs change 1 time unit after a rising edge; outputs are checked at the
//   same point, so every check sees the state left by the preceding edge.
// ---------------------------------------------------------------------------
module tb_seg7_ascii_reader;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic pulse_seen;
    logic [7:0] drain_exp [8];

    seg7_ascii_reader_if #(.DEPTH(8)) bus ();

    seg7_ascii_reader #(
        .STABLE_CYCLES(4),
        .DEPTH        (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a glyph and hold it until it has been accepted: first sample on
    // the next edge k, push on edge k+4, returns just after the push edge.
    task automatic feed(input logic [6:0] pat);
        bus.seg_in = pat;
        tick(5);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.seg_in      = 7'h7F;
        bus.ascii_ready = 1'b0;

        // ---- 1: reset state, idle blank bus --------------------------------
        tick(3);
        chk("rst_out",   {24'd0, bus.ascii_out},   32'h00);
        chk("rst_valid", {31'd0, bus.ascii_valid}, 32'd0);
        chk("rst_err",   {31'd0, bus.decode_err},  32'd0);
        chk("rst_ovf",   {31'd0, bus.overflow},    32'd0);
        chk("rst_count", {28'd0, bus.fifo_count},  32'd0);
        reset      = 1'b0;
        pulse_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            pulse_seen = pulse_seen | bus.decode_err | bus.overflow | bus.ascii_valid;
        end
        chk("idle_activity", {31'd0, pulse_seen},       32'd0);
        chk("idle_count",    {28'd0, bus.fifo_count},   32'd0);

        // ---- 2: latency of a single glyph 'A' ------------------------------
        bus.ascii_ready = 1'b1;
        bus.seg_in      = 7'h08;
        tick(4);
        chk("lat_not_yet", {31'd0, bus.ascii_valid}, 32'd0);
        tick(1);
        chk("lat_valid",   {31'd0, bus.ascii_valid}, 32'd1);
        chk("lat_out",     {24'd0, bus.ascii_out},   32'h41);
        chk("lat_count",   {28'd0, bus.fifo_count},  32'd1);
        tick(1);
        chk("lat_popped",  {28'd0, bus.fifo_count},  32'd0);
        chk("lat_hold",    {24'd0, bus.ascii_out},   32'h41);

        // ---- 3: glitch rejection, then a held 'H' --------------------------
        bus.ascii_ready = 1'b0;
        bus.seg_in      = 7'h09;
        tick(3);
        bus.seg_in      = 7'h08;
        tick(10);
        chk("glitch_count", {28'd0, bus.fifo_count}, 32'd0);
        feed(7'h09);
        chk("held_count", {28'd0, bus.fifo_count}, 32'd1);
        chk("held_out",   {24'd0, bus.ascii_out},  32'h48);
        bus.ascii_ready = 1'b1;
        tick(1);
        bus.ascii_ready = 1'b0;
        chk("held_drain", {28'd0, bus.fifo_count}, 32'd0);

        // ---- 4: fill past capacity with digits 0..8 ------------------------
        feed(7'h40); feed(7'h79); feed(7'h24); feed(7'h30);
        feed(7'h19); feed(7'h12); feed(7'h02); feed(7'h78);
        chk("fill_count8",   {28'd0, bus.fifo_count}, 32'd8);
        chk("fill_no_ovf",   {31'd0, bus.overflow},   32'd0);
        feed(7'h00);
        chk("fill_ovf",      {31'd0, bus.overflow},   32'd1);
        chk("fill_still8",   {28'd0, bus.fifo_count}, 32'd8);
        tick(1);
        chk("fill_ovf_end",  {31'd0, bus.overflow},   32'd0);
        drain_exp[0] = 8'h30; drain_exp[1] = 8'h31; drain_exp[2] = 8'h32; drain_exp[3] = 8'h33;
        drain_exp[4] = 8'h34; drain_exp[5] = 8'h35; drain_exp[6] = 8'h36; drain_exp[7] = 8'h37;
        bus.ascii_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_%0d", i), {24'd0, bus.ascii_out}, {24'd0, drain_exp[i]});
            tick(1);
        end
        bus.ascii_ready = 1'b0;
        chk("drain_empty", {31'd0, bus.ascii_valid}, 32'd0);
        chk("drain_hold",  {24'd0, bus.ascii_out},   32'h37);

        // ---- 5: unknown pattern then blank ---------------------------------
        feed(7'h7E);
        chk("unk_err",    {31'd0, bus.decode_err}, 32'd1);
        chk("unk_out",    {24'd0, bus.ascii_out},  32'h3F);
        tick(1);
        chk("unk_err_end", {31'd0, bus.decode_err}, 32'd0);
        feed(7'h7F);
        chk("blank_count", {28'd0, bus.fifo_count}, 32'd2);
        chk("blank_no_err", {31'd0, bus.decode_err}, 32'd0);
        bus.ascii_ready = 1'b1;
        chk("blank_head0", {24'd0, bus.ascii_out}, 32'h3F);
        tick(1);
        chk("blank_head1", {24'd0, bus.ascii_out}, 32'h20);
        tick(1);
        bus.ascii_ready = 1'b0;
        chk("blank_drained", {28'd0, bus.fifo_count}, 32'd0);

        // ---- 6: push into a full FIFO on a pop edge, then reset mid-SETTLE -
        feed(7'h07); feed(7'h03); feed(7'h4F); feed(7'h09);
        feed(7'h08); feed(7'h40); feed(7'h79); feed(7'h24);
        chk("full_count",   {28'd0, bus.fifo_count}, 32'd8);
        chk("full_head",    {24'd0, bus.ascii_out},  32'h54);
        bus.seg_in = 7'h30;
        tick(4);
        bus.ascii_ready = 1'b1;
        tick(1);
        bus.ascii_ready = 1'b0;
        chk("pp_no_ovf",  {31'd0, bus.overflow},   32'd0);
        chk("pp_count",   {28'd0, bus.fifo_count}, 32'd8);
        chk("pp_head",    {24'd0, bus.ascii_out},  32'h42);

        bus.seg_in = 7'h19;
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_out",   {24'd0, bus.ascii_out},   32'h00);
        chk("mid_rst_valid", {31'd0, bus.ascii_valid}, 32'd0);
        chk("mid_rst_count", {28'd0, bus.fifo_count},  32'd0);
        chk("mid_rst_err",   {31'd0, bus.decode_err},  32'd0);
        chk("mid_rst_ovf",   {31'd0, bus.overflow},    32'd0);
        tick(2);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
